// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between IF and D; D wins ties (optional fairness via MEMARB_FAIR_EN).
// Latency: request sampled in IDLE at t -> mem_en_o at t+1 -> stall released at t+LAT+2; one transaction in flight.
// Backpressure: each requester holds its request while its combinational stall is high.
module mem_port_arbiter #(
    parameter int WORD       = 32,
    parameter int ADDR       = 16,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_i,
    input  logic [ADDR-1:0] if_addr_i,
    output logic [WORD-1:0] if_inst_o,
    output logic            if_stall_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [ADDR-1:0] d_addr_i,
    input  logic [WORD-1:0] d_wdata_i,
    output logic [WORD-1:0] d_rdata_o,
    output logic            d_stall_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [ADDR-1:0] mem_addr_o,
    output logic [WORD-1:0] mem_wdata_o,
    input  logic [WORD-1:0] mem_rdata_i
);

    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic            owner_d;
    logic [CW-1:0]   cnt;
    logic [ADDR-1:0] addr_q;
    logic            we_q;
    logic [WORD-1:0] wdata_q;
    logic            any_req;
    logic            grant_d;

    assign any_req = if_req_i | d_req_i;

`ifdef MEMARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1) + 1;
    logic [SW-1:0] starve;

    // IF overrides D once it has been passed over STARVE_MAX times in a row
    assign grant_d = d_req_i & ~(if_req_i & (starve == SW'(STARVE_MAX)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (state == IDLE && any_req) begin
            if (grant_d && if_req_i) starve <= starve + 1'b1;
            else                     starve <= '0;
        end
    end
`else
    assign grant_d = d_req_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en_o    = (state == ISSUE);
        mem_we_o    = (state == ISSUE) & we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if_stall_o  = if_req_i & ~((state == DONE) & ~owner_d);
        d_stall_o   = d_req_i  & ~((state == DONE) &  owner_d);
    end

    // WAIT lasts LAT cycles; the last one is the cycle memory data is valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt       <= '0;
            if_inst_o <= '0;
            d_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d <= grant_d;
                        addr_q  <= grant_d ? d_addr_i : if_addr_i;
                        we_q    <= grant_d & d_we_i;
                        if (grant_d) wdata_q <= d_wdata_i;
                    end
                end
                ISSUE: cnt <= CW'(LAT - 1);
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!owner_d) begin
                        if_inst_o <= mem_rdata_i;
                    end else if (!we_q) begin
                        d_rdata_o <= mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-timeline model and a reference memory.
module tb_mem_port_arbiter;

    localparam int WORD = 32;
    localparam int ADDR = 8;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, d_req, d_we;
    logic [ADDR-1:0] if_addr, d_addr;
    logic [WORD-1:0] d_wdata;
    logic [WORD-1:0] if_inst_o, d_rdata_o, mem_wdata_o, mem_rdata_i;
    logic            if_stall_o, d_stall_o, mem_en_o, mem_we_o;
    logic [ADDR-1:0] mem_addr_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_port_arbiter #(.WORD(WORD), .ADDR(ADDR), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_inst_o(if_inst_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: read data appears LAT cycles after the command, garbage otherwise
    logic [WORD-1:0] dev_mem [256];
    logic [WORD-1:0] ref_mem [256];
    logic [WORD-1:0] pipe [LAT];
    assign mem_rdata_i = pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_en_o && mem_we_o) dev_mem[mem_addr_o] <= mem_wdata_o;
        for (int i = LAT - 1; i >= 1; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= mem_en_o ? dev_mem[mem_addr_o] : $urandom;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a grant at cycle tg issues at tg+1, completes at tg+LAT+2, frees the port at tg+LAT+3
    logic            m_busy = 1'b0;
    logic            m_own_d, m_we;
    logic [ADDR-1:0] m_addr, sh_addr;
    logic [WORD-1:0] m_wdata, e_if, e_d;
    logic            e_en, e_done;
    int              tg = 0;
    int              starve = 0;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0; e_if = '0; e_d = '0; sh_addr = '0; starve = 0;
            e_en = 1'b0; e_done = 1'b0;
        end else begin
            if (m_busy && cyc >= tg + LAT + 3) m_busy = 1'b0;
            e_en   = m_busy && (cyc == tg + 1);
            e_done = m_busy && (cyc == tg + LAT + 2);
            if (e_en) begin
                sh_addr = m_addr;
                if (m_we) ref_mem[m_addr] = m_wdata;
            end
            if (e_done && !m_we) begin
                if (m_own_d) e_d  = ref_mem[m_addr];
                else         e_if = ref_mem[m_addr];
            end
        end
        chk("m_if_stall", 32'(if_stall_o), 32'(if_req & ~(e_done & ~m_own_d)));
        chk("m_d_stall",  32'(d_stall_o),  32'(d_req  & ~(e_done &  m_own_d)));
        chk("m_mem_en",   32'(mem_en_o),   32'(e_en));
        chk("m_mem_we",   32'(mem_we_o),   32'(e_en & m_we));
        chk("m_mem_addr", 32'(mem_addr_o), 32'(sh_addr));
        if (!rst)             chk("m_wdata_rst", mem_wdata_o, 0);
        else if (e_en && m_we) chk("m_wdata",    mem_wdata_o, m_wdata);
        chk("m_if_inst",  if_inst_o, e_if);
        chk("m_d_rdata",  d_rdata_o, e_d);
        if (rst && !m_busy && (if_req || d_req)) begin
            m_busy = 1'b1;
            tg     = cyc;
`ifdef MEMARB_FAIR_EN
            m_own_d = d_req && !(if_req && starve == SMAX);
            if (m_own_d && if_req) starve = starve + 1;
            else                   starve = 0;
`else
            m_own_d = d_req;
`endif
            m_addr  = m_own_d ? d_addr : if_addr;
            m_we    = m_own_d & d_we;
            m_wdata = d_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int if_iss;

    initial begin
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
            ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
        end
        dev_mem[5] = 32'hDEAD; ref_mem[5] = 32'hDEAD;
        dev_mem[8] = 32'h88;   ref_mem[8] = 32'h88;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;

        // Reset state; stall follows the request even in reset
        step();
        if_req = 1'b1;
        @(negedge clk);
        chk("rst_en", 32'(mem_en_o), 0);
        chk("rst_inst", if_inst_o, 0);
        chk("rst_rdata", d_rdata_o, 0);
        chk("rst_if_stall", 32'(if_stall_o), 1);
        chk("rst_d_stall", 32'(d_stall_o), 0);
        step();
        if_req = 1'b0; rst = 1'b1;
        step();

        // T1: single IF read
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) begin if_req = 1; if_addr = 5; end
            if (k == 5) if_req = 0;
            @(negedge clk);
            if (k == 1) begin chk("t1_en", 32'(mem_en_o), 1); chk("t1_addr", 32'(mem_addr_o), 5); end
            if (k <= 3) chk("t1_stall_hi", 32'(if_stall_o), 1);
            if (k == 4) begin chk("t1_stall_lo", 32'(if_stall_o), 0); chk("t1_inst", if_inst_o, 32'hDEAD); end
            step();
        end

        // T2: simultaneous requests, D first
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) begin d_req = 1; d_we = 0; d_addr = 8; if_req = 1; if_addr = 5; end
            if (k == 5) d_req = 0;
            if (k == 10) if_req = 0;
            @(negedge clk);
            if (k == 1) chk("t2_d_addr", 32'(mem_addr_o), 8);
            if (k == 4) begin
                chk("t2_d_stall", 32'(d_stall_o), 0);
                chk("t2_d_rdata", d_rdata_o, 32'h88);
                chk("t2_if_wait", 32'(if_stall_o), 1);
            end
            if (k == 6) begin chk("t2_if_en", 32'(mem_en_o), 1); chk("t2_if_addr", 32'(mem_addr_o), 5); end
            if (k == 9) begin chk("t2_if_stall", 32'(if_stall_o), 0); chk("t2_inst", if_inst_o, 32'hDEAD); end
            step();
        end

        // T3: D write then IF readback; command changes after capture are ignored
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) begin d_req = 1; d_we = 1; d_addr = 3; d_wdata = 32'h1234; end
            if (k == 1) begin d_addr = 9; d_wdata = 32'hFFFF; end
            if (k == 5) begin d_req = 0; d_we = 0; if_req = 1; if_addr = 3; end
            if (k == 10) if_req = 0;
            @(negedge clk);
            if (k == 1) begin
                chk("t3_we", 32'(mem_we_o), 1);
                chk("t3_wdata", mem_wdata_o, 32'h1234);
                chk("t3_addr", 32'(mem_addr_o), 3);
            end
            if (k == 4) chk("t3_d_rdata_hold", d_rdata_o, 32'h88);
            if (k == 9) begin chk("t3_inst", if_inst_o, 32'h1234); chk("t3_d_rdata", d_rdata_o, 32'h88); end
            step();
        end

        // T4: both held high for 100 cycles
        if_iss = 0;
        for (int k = 0; k <= 100; k++) begin
            if (k == 0) begin d_req = 1; d_we = 0; d_addr = 8; if_req = 1; if_addr = 5; end
            if (k == 100) begin d_req = 0; if_req = 0; end
            @(negedge clk);
            if (k < 100 && mem_en_o && mem_addr_o == 5) if_iss++;
            step();
        end
`ifdef MEMARB_FAIR_EN
        chk("t4_if_grants", 32'(if_iss), 4);
`else
        chk("t4_if_grants", 32'(if_iss), 0);
`endif
        step();

        // T5: reset during WAIT abandons the read; a fresh read follows T1 timing
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) begin if_req = 1; if_addr = 5; end
            if (k == 2) rst = 0;
            if (k == 3) rst = 1;
            if (k == 8) if_req = 0;
            @(negedge clk);
            if (k == 2) begin
                chk("t5_en", 32'(mem_en_o), 0);
                chk("t5_inst", if_inst_o, 0);
                chk("t5_rdata", d_rdata_o, 0);
                chk("t5_addr", 32'(mem_addr_o), 0);
                chk("t5_stall", 32'(if_stall_o), 1);
            end
            if (k == 3) chk("t5_idle_en", 32'(mem_en_o), 0);
            if (k == 4) begin chk("t5_reissue", 32'(mem_en_o), 1); chk("t5_readdr", 32'(mem_addr_o), 5); end
            if (k == 6) chk("t5_stall_hi", 32'(if_stall_o), 1);
            if (k == 7) begin chk("t5_stall_lo", 32'(if_stall_o), 0); chk("t5_inst_ok", if_inst_o, 32'hDEAD); end
            step();
        end

        // T6: D write whose request drops mid-flight still lands; IF gets the next IDLE
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) begin d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'h7777; end
            if (k == 2) begin d_req = 0; d_we = 0; if_req = 1; if_addr = 7; end
            if (k == 10) if_req = 0;
            @(negedge clk);
            if (k == 1) begin chk("t6_we", 32'(mem_we_o), 1); chk("t6_wdata", mem_wdata_o, 32'h7777); end
            if (k == 3) chk("t6_d_stall", 32'(d_stall_o), 0);
            if (k == 6) begin
                chk("t6_if_en", 32'(mem_en_o), 1);
                chk("t6_if_addr", 32'(mem_addr_o), 7);
                chk("t6_if_we", 32'(mem_we_o), 0);
            end
            if (k == 9) begin chk("t6_stall_lo", 32'(if_stall_o), 0); chk("t6_inst", if_inst_o, 32'h7777); end
            step();
        end

        // Random traffic, including mid-flight drops, address churn and occasional resets
        for (int n = 0; n < 3000; n++) begin
            if (!rst) rst = 1;
            else if ($urandom_range(0, 199) == 0) rst = 0;
            if (if_req) begin
                if ($urandom_range(0, 7) == 0) if_req = 0;
                else if ($urandom_range(0, 7) == 0) if_addr = ADDR'($urandom_range(0, 15));
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = ADDR'($urandom_range(0, 15));
            end
            if (d_req) begin
                if ($urandom_range(0, 7) == 0) d_req = 0;
                else if ($urandom_range(0, 7) == 0) begin
                    d_addr = ADDR'($urandom_range(0, 15)); d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = ADDR'($urandom_range(0, 15)); d_wdata = $urandom;
            end
            step();
        end
        rst = 1; if_req = 0; d_req = 0;
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
